// File: rtl/alu_control_sequencer_pkg.sv
// cpu_ctrl_pkg: shared definitions for the hardwired ALU control sequencer.
//   state_e          - control step encoding (IDLE, T0..T6, DONE)
//   Opc*             - supported opcode constants (IR[31:27])
//   is_3reg()        - true for the register-register ALU class
//   is_muldiv()      - true for MUL/DIV
//   alu_code()       - ALU OP code for a supported opcode, 0 otherwise
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StT0,
        StT1,
        StT2,
        StT3,
        StT4,
        StT5,
        StT6,
        StDone
    } state_e;

    localparam logic [4:0] OpcAdd  = 5'b00011;
    localparam logic [4:0] OpcSub  = 5'b00100;
    localparam logic [4:0] OpcAnd  = 5'b00101;
    localparam logic [4:0] OpcOr   = 5'b00110;
    localparam logic [4:0] OpcShr  = 5'b00111;
    localparam logic [4:0] OpcShra = 5'b01000;
    localparam logic [4:0] OpcShl  = 5'b01001;
    localparam logic [4:0] OpcRor  = 5'b01010;
    localparam logic [4:0] OpcRol  = 5'b01011;
    localparam logic [4:0] OpcMul  = 5'b01111;
    localparam logic [4:0] OpcDiv  = 5'b10000;

    // The three-register opcodes occupy one contiguous range.
    function automatic logic is_3reg(input logic [4:0] opc);
        return opc inside {[OpcAdd:OpcRol]};
    endfunction

    function automatic logic is_muldiv(input logic [4:0] opc);
        return (opc == OpcMul) || (opc == OpcDiv);
    endfunction

    function automatic logic [4:0] alu_code(input logic [4:0] opc);
        return (is_3reg(opc) || is_muldiv(opc)) ? opc + 5'd1 : 5'd0;
    endfunction

endpackage

// File: rtl/alu_control_sequencer_if.sv
// Control bundle between the sequencer, the memory handshake and the datapath.
//   Inputs to the sequencer : Run, MemReady, IR[31:0]
//   Outputs of the sequencer: datapath strobes, Rin/Rout[NREG-1:0] one-hot
//                             selects, OP[4:0], Done and Illegal pulses
// master = sequencer side, slave = datapath/memory side.
interface alu_control_sequencer_if #(
    parameter int unsigned NREG = 16
);
    logic            Run;
    logic            MemReady;
    logic [31:0]     IR;

    logic            PCout, MARin, IncPC, ZLowin, ZHighin, ZLowout, ZHighout, PCin;
    logic            Read, MDRin, MDRout, IRin, Yin, HIin, LOin;
    logic [NREG-1:0] Rin;
    logic [NREG-1:0] Rout;
    logic [4:0]      OP;
    logic            Done;
    logic            Illegal;

    modport master (
        input  Run, MemReady, IR,
        output PCout, MARin, IncPC, ZLowin, ZHighin, ZLowout, ZHighout, PCin,
               Read, MDRin, MDRout, IRin, Yin, HIin, LOin, Rin, Rout, OP, Done, Illegal
    );

    modport slave (
        output Run, MemReady, IR,
        input  PCout, MARin, IncPC, ZLowin, ZHighin, ZLowout, ZHighout, PCin,
               Read, MDRin, MDRout, IRin, Yin, HIin, LOin, Rin, Rout, OP, Done, Illegal
    );

endinterface

// File: rtl/alu_control_sequencer_reg_select_decoder.sv
// reg_select_decoder: 4-to-Width one-hot decoder with enable.
//   sel    in 4     : register index
//   en     in 1     : when low the output is all zeros
//   onehot out Width: one-hot select (zero when disabled or sel >= Width)
module reg_select_decoder #(
    parameter int unsigned Width = 16
) (
    input  logic [3:0]       sel,
    input  logic             en,
    output logic [Width-1:0] onehot
);

    assign onehot = en ? (Width'(1) << sel) : '0;

endmodule

// File: rtl/alu_control_sequencer.sv
// alu_control_sequencer: hardwired control unit for the single-bus datapath.
// Fetches through PC/MAR/MDR with a MemReady wait in T1, decodes the
// three-register ALU class and MUL/DIV, and emits the T0..T6 control steps.
//   Clock in 1 : rising-edge clock
//   Clear in 1 : synchronous active-high reset, aborts any instruction
//   bus        : master side of alu_control_sequencer_if (Run, MemReady, IR in;
//                strobes, Rin/Rout, OP, Done, Illegal out)
module alu_control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned NREG = 16
) (
    input  logic                    Clock,
    input  logic                    Clear,
    alu_control_sequencer_if.master bus
);

    state_e     state_q, state_d;
    logic       first_q;   // high in the first T1 cycle only
    logic [4:0] opc;
    logic [3:0] ra, rb, rc;
    logic       rin_en, rout_en;
    logic [3:0] rin_sel, rout_sel;
    logic       unused_ir;

    assign opc       = bus.IR[31:27];
    assign ra        = bus.IR[26:23];
    assign rb        = bus.IR[22:19];
    assign rc        = bus.IR[18:15];
    assign unused_ir = ^bus.IR[14:0];

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q <= StIdle;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= (state_q == StT0);
        end
    end

    always_comb begin
        state_d      = state_q;
        bus.PCout    = 1'b0;
        bus.MARin    = 1'b0;
        bus.IncPC    = 1'b0;
        bus.ZLowin   = 1'b0;
        bus.ZHighin  = 1'b0;
        bus.ZLowout  = 1'b0;
        bus.ZHighout = 1'b0;
        bus.PCin     = 1'b0;
        bus.Read     = 1'b0;
        bus.MDRin    = 1'b0;
        bus.MDRout   = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
        bus.OP       = 5'd0;
        bus.Done     = 1'b0;
        bus.Illegal  = 1'b0;
        rin_en       = 1'b0;
        rout_en      = 1'b0;
        rin_sel      = ra;
        rout_sel     = rb;

        unique case (state_q)
            StIdle: begin
                if (bus.Run) state_d = StT0;
            end
            StT0: begin
                bus.PCout   = 1'b1;
                bus.MARin   = 1'b1;
                bus.IncPC   = 1'b1;
                bus.ZLowin  = 1'b1;
                bus.ZHighin = 1'b1;
                state_d     = StT1;
            end
            StT1: begin
                // PC update happens once; the read is held across wait cycles.
                bus.ZLowout = first_q;
                bus.PCin    = first_q;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
                if (bus.MemReady) state_d = StT2;
            end
            StT2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                state_d    = StT3;
            end
            StT3: begin
                if (is_3reg(opc) || is_muldiv(opc)) begin
                    rout_en  = 1'b1;
                    rout_sel = is_muldiv(opc) ? ra : rb;
                    bus.Yin  = 1'b1;
                    state_d  = StT4;
                end else begin
                    bus.Illegal = 1'b1;
                    state_d     = StDone;
                end
            end
            StT4: begin
                rout_en    = 1'b1;
                rout_sel   = is_muldiv(opc) ? rb : rc;
                bus.OP     = alu_code(opc);
                bus.ZLowin = 1'b1;
                bus.ZHighin = is_muldiv(opc);
                state_d    = StT5;
            end
            StT5: begin
                bus.ZLowout = 1'b1;
                if (is_muldiv(opc)) begin
                    bus.LOin = 1'b1;
                    state_d  = StT6;
                end else begin
                    rin_en  = 1'b1;
                    state_d = StDone;
                end
            end
            StT6: begin
                bus.ZHighout = 1'b1;
                bus.HIin     = 1'b1;
                state_d      = StDone;
            end
            StDone: begin
                bus.Done = 1'b1;
                state_d  = bus.Run ? StT0 : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    reg_select_decoder #(
        .Width (NREG)
    ) u_rin_dec (
        .sel    (rin_sel),
        .en     (rin_en),
        .onehot (bus.Rin)
    );

    reg_select_decoder #(
        .Width (NREG)
    ) u_rout_dec (
        .sel    (rout_sel),
        .en     (rout_en),
        .onehot (bus.Rout)
    );

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Self-checking bench for alu_control_sequencer. A step-list model builds the
// expected output vector of every cycle of an instruction from the control
// step table; one compare process checks the DUT against it each cycle.
module tb_alu_control_sequencer;

    typedef struct packed {
        logic        PCout, MARin, IncPC, ZLowin, ZHighin, ZLowout, ZHighout, PCin;
        logic        Read, MDRin, MDRout, IRin, Yin, HIin, LOin;
        logic [15:0] Rin;
        logic [15:0] Rout;
        logic [4:0]  OP;
        logic        Done;
        logic        Illegal;
    } outs_t;

    logic  Clock;
    logic  Clear;
    int    checks;
    int    failures;
    int    cycle;
    outs_t exp_cur;
    logic  exp_valid;
    logic  in_idle;
    outs_t exp_q[$];
    bit    mem_q[$];

    alu_control_sequencer_if #(.NREG(16)) bus ();

    alu_control_sequencer #(
        .NREG (16)
    ) dut (
        .Clock (Clock),
        .Clear (Clear),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic outs_t dut_outs();
        outs_t a;
        a.PCout = bus.PCout;     a.MARin = bus.MARin;       a.IncPC = bus.IncPC;
        a.ZLowin = bus.ZLowin;   a.ZHighin = bus.ZHighin;   a.ZLowout = bus.ZLowout;
        a.ZHighout = bus.ZHighout; a.PCin = bus.PCin;       a.Read = bus.Read;
        a.MDRin = bus.MDRin;     a.MDRout = bus.MDRout;     a.IRin = bus.IRin;
        a.Yin = bus.Yin;         a.HIin = bus.HIin;         a.LOin = bus.LOin;
        a.Rin = bus.Rin;         a.Rout = bus.Rout;         a.OP = bus.OP;
        a.Done = bus.Done;       a.Illegal = bus.Illegal;
        return a;
    endfunction

    // Single compare process, away from the active edge.
    always @(negedge Clock) begin
        if (exp_valid) begin
            outs_t act;
            act = dut_outs();
            checks++;
            if (act !== exp_cur) begin
                failures++;
                $display("FAIL cycle_outputs cycle=%0d got=%h want=%h", cycle, act, exp_cur);
            end
        end
    end

    task automatic check_eq(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    function automatic logic [15:0] oh(input logic [3:0] i);
        return 16'h0001 << i;
    endfunction

    // Expected per-cycle outputs (and MemReady to apply) for one instruction.
    task automatic gen_seq(input logic [31:0] ir, input int waits);
        outs_t o;
        logic [4:0] opc;
        logic [3:0] ra, rb, rc;
        bit three, md;
        opc = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
        three = (opc >= 5'd3) && (opc <= 5'd11);
        md = (opc == 5'd15) || (opc == 5'd16);
        exp_q.delete();
        mem_q.delete();
        o = '0; o.PCout = 1; o.MARin = 1; o.IncPC = 1; o.ZLowin = 1; o.ZHighin = 1;
        exp_q.push_back(o); mem_q.push_back(1'($urandom));
        for (int w = 0; w <= waits; w++) begin
            o = '0; o.Read = 1; o.MDRin = 1;
            if (w == 0) begin o.ZLowout = 1; o.PCin = 1; end
            exp_q.push_back(o); mem_q.push_back(w == waits);
        end
        o = '0; o.MDRout = 1; o.IRin = 1;
        exp_q.push_back(o); mem_q.push_back(1'($urandom));
        if (!three && !md) begin
            o = '0; o.Illegal = 1;
            exp_q.push_back(o); mem_q.push_back(1'($urandom));
        end else if (three) begin
            o = '0; o.Rout = oh(rb); o.Yin = 1;
            exp_q.push_back(o); mem_q.push_back(1'($urandom));
            o = '0; o.Rout = oh(rc); o.OP = opc + 5'd1; o.ZLowin = 1;
            exp_q.push_back(o); mem_q.push_back(1'($urandom));
            o = '0; o.ZLowout = 1; o.Rin = oh(ra);
            exp_q.push_back(o); mem_q.push_back(1'($urandom));
        end else begin
            o = '0; o.Rout = oh(ra); o.Yin = 1;
            exp_q.push_back(o); mem_q.push_back(1'($urandom));
            o = '0; o.Rout = oh(rb); o.OP = opc + 5'd1; o.ZLowin = 1; o.ZHighin = 1;
            exp_q.push_back(o); mem_q.push_back(1'($urandom));
            o = '0; o.ZLowout = 1; o.LOin = 1;
            exp_q.push_back(o); mem_q.push_back(1'($urandom));
            o = '0; o.ZHighout = 1; o.HIin = 1;
            exp_q.push_back(o); mem_q.push_back(1'($urandom));
        end
        o = '0; o.Done = 1;
        exp_q.push_back(o); mem_q.push_back(1'($urandom));
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
        cycle++;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            Clear = 0; bus.Run = 0; bus.MemReady = 1'($urandom);
            exp_cur = '0; exp_valid = 1;
            step();
        end
        in_idle = 1;
    endtask

    // abort_at < 0: run to completion; otherwise assert Clear in that step.
    task automatic play(input logic [31:0] ir, input int waits, input bit run_at_done,
                        input int abort_at);
        if (in_idle) begin
            Clear = 0; bus.Run = 1; bus.MemReady = 1'($urandom);
            exp_cur = '0; exp_valid = 1;
            step();
        end
        gen_seq(ir, waits);
        bus.IR = ir;
        for (int i = 0; i < exp_q.size(); i++) begin
            Clear = (i == abort_at);
            bus.MemReady = mem_q[i];
            bus.Run = (i == exp_q.size() - 1) ? run_at_done : 1'($urandom);
            exp_cur = exp_q[i]; exp_valid = 1;
            step();
            if (i == abort_at) begin
                in_idle = 1;
                return;
            end
        end
        in_idle = !run_at_done;
    endtask

    function automatic logic [31:0] make_ir(input logic [4:0] opc, input logic [3:0] a,
                                            input logic [3:0] b, input logic [3:0] c);
        return {opc, a, b, c, 15'(($urandom))};
    endfunction

    initial begin
        int rd;
        logic [4:0] legal [11];
        checks = 0; failures = 0; cycle = 0;
        exp_valid = 0; exp_cur = '0; in_idle = 1;
        Clear = 1; bus.Run = 1; bus.MemReady = 0; bus.IR = '0;
        legal = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd15, 5'd16};

        // Pin the model against hand-computed expectations.
        gen_seq(32'h5B32_0000, 0);
        check_eq("rol_len", exp_q.size(), 7);
        check_eq("rol_t3_rout", int'(exp_q[3].Rout), 'h0040);
        check_eq("rol_t3_yin", int'(exp_q[3].Yin), 1);
        check_eq("rol_t4_rout", int'(exp_q[4].Rout), 'h0010);
        check_eq("rol_t4_op", int'(exp_q[4].OP), 'b01100);
        check_eq("rol_t5_rin", int'(exp_q[5].Rin), 'h0040);
        check_eq("rol_done", int'(exp_q[6].Done), 1);
        gen_seq(32'h5B32_0000, 3);
        check_eq("wait_len", exp_q.size(), 10);
        rd = 0;
        foreach (exp_q[i]) rd += int'(exp_q[i].Read);
        check_eq("wait_read_cycles", rd, 4);
        gen_seq({5'b01111, 4'd2, 4'd3, 19'd0}, 0);
        check_eq("mul_len", exp_q.size(), 8);
        check_eq("mul_t4_op", int'(exp_q[4].OP), 'b10000);
        check_eq("mul_t6_hiin", int'(exp_q[6].HIin), 1);
        gen_seq({5'b11111, 27'd0}, 0);
        check_eq("ill_len", exp_q.size(), 5);
        check_eq("ill_t3", int'(exp_q[3].Illegal), 1);

        // Reset: two Clear cycles with Run high; second one is checked.
        step();
        exp_cur = '0; exp_valid = 1;
        step();
        in_idle = 1;

        // Directed cases.
        play(32'h5B32_0000, 0, 1, -1);                       // ROL back-to-back
        play(32'h5B32_0000, 3, 1, -1);                       // memory wait
        play({5'b01111, 4'd2, 4'd3, 19'd0}, 0, 1, -1);       // MUL
        play({5'b11111, 4'd1, 4'd2, 4'd3, 15'd0}, 1, 1, -1); // illegal
        play(make_ir(5'd3, 4'd1, 4'd2, 4'd3), 0, 1, 4);      // ADD aborted in T4
        play(make_ir(5'd3, 4'd5, 4'd5, 4'd7), 0, 0, -1);     // ADD, Run dropped
        idle_cycles(3);

        // Randomized instruction stream.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] ir;
            int waits, abort_at;
            if ($urandom_range(0, 9) == 0) ir = {5'($urandom), 27'($urandom)};
            else ir = make_ir(legal[$urandom_range(0, 10)], 4'($urandom), 4'($urandom),
                              4'($urandom));
            waits = $urandom_range(0, 3);
            abort_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : -1;
            play(ir, waits, $urandom_range(0, 3) != 0, abort_at);
            if (in_idle && $urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
        end
        idle_cycles(2);

        exp_valid = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
